num_formatter: RTL and testbench
================================

NUM_FORMATTER -- requirements
Module: num_formatter

Interface
REQ-001 SHALL have parameter NumDigits, default 8: BCD significand digits, minimum 2.
REQ-002 SHALL have parameter ExpWidth, default 8: width of signed two's-complement exponent, range 2..16.
REQ-003 SHALL have parameter AppendNewline, default 1: when 1, append ASCII 0x0A as the final character.
REQ-004 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset; it is synchronous and active-low.
REQ-006 SHALL have port in_valid_i, input, 1: number offered.
REQ-007 SHALL have port in_ready_o, output, 1: number accepted when high together with in_valid_i.
REQ-008 SHALL have port error_i, input, 1: error flag.
REQ-009 SHALL have port sign_i, input, 1: 1 means negative.
REQ-010 SHALL have port significand_i, input, 4*NumDigits: digit i at bits [4i+3:4i]; digit NumDigits-1 precedes the point.
REQ-011 SHALL have port exponent_i, input, ExpWidth: signed decimal exponent.
REQ-012 SHALL have port compact_i, input, 1: format select, sampled with the number.
REQ-013 SHALL have port out_valid_o, output, 1: character available.
REQ-014 SHALL have port out_ready_i, input, 1: character consumed when high together with out_valid_o.
REQ-015 SHALL have port out_char_o, output, 8: ASCII character.
REQ-016 SHALL have port out_last_o, output, 1: final character of the string.
REQ-017 SHALL have port busy_o, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL implement states IDLE, CONVERT, EMIT; in_ready_o is high only in IDLE.
REQ-019 SHALL register all inputs on an in_valid_i && in_ready_o handshake and enter CONVERT on the next cycle.
REQ-020 SHALL, in CONVERT, turn |exponent| into BCD by double-dabble, one bit per cycle, taking exactly ExpWidth cycles; out_valid_o first rises ExpWidth+1 cycles after the handshake.
REQ-021 SHALL use magnitude 2^(ExpWidth-1) for the most negative exponent, without overflow (-128 -> "128").
REQ-022 SHALL emit in full mode (compact 0): err, sign, d[N-1], '.', d[N-2]..d[0], " x 10^", optional '-', exponent digits, optional newline.
REQ-023 SHALL emit in compact mode (compact 1): err, sign, d[N-1], '.', d[N-2]..d[0], 'e', optional '-', exponent digits, optional newline.
REQ-024 SHALL set err to 'E' when error is set, else ' '; sign to '-' when sign is set, else ' '.
REQ-025 SHALL print each significand digit 0..9 as '0'..'9', and digits 0xA..0xF as '?'.
REQ-026 SHALL print exponent digits without leading zeros and at least one digit; '-' only when the exponent is negative; zero prints "0".
REQ-027 SHALL raise out_last_o only with the final character (newline, or last exponent digit when AppendNewline=0).
REQ-028 SHALL hold out_char_o and out_last_o stable while out_valid_o && !out_ready_i, advancing one character per accepted beat.
REQ-029 SHALL return to IDLE in the cycle after the last beat is accepted; in_ready_o rises then, so a new number cannot be accepted in the same cycle as the last beat.
REQ-030 SHALL ignore in_valid_i and all data inputs while busy_o is high.

Reset
REQ-031 SHALL, when rst_ni is low at a clock edge, enter IDLE, drive in_ready_o=1 and out_valid_o=out_last_o=busy_o=0, drive out_char_o=0x00, and clear the converter, from any state.
REQ-032 SHALL produce no further characters of an interrupted string after reset, and the next string SHALL be complete.

Verification
REQ-033 SHALL check, with digits 1,2,3,4,5,6,7,8 (d7=1), sign 1, error 0, exp -12, full, out_ready_i tied high: output is " -1.2345678 x 10^-12\n", 21 beats, out_valid_o first high at handshake+9 cycles.
REQ-034 SHALL check, with all digits 0, exp 0, error 1, compact: output is "E 0.0000000e0\n", out_last_o only on 0x0A.
REQ-035 SHALL check, with exp -128 and d0=0xA: the tail is "x 10^-128\n" and the final significand character is '?'.
REQ-036 SHALL check, with out_ready_i randomly deasserted 50% of the time: the string is identical and out_char_o is stable during stalls.
REQ-037 SHALL check, with rst_ni low for one cycle at the fifth beat, then a new number (exp 7, compact): only the new complete string appears, ending "e7\n".
REQ-038 SHALL check, with NumDigits=4, ExpWidth=4, AppendNewline=0, exp -8: output is "  d.ddd x 10^-8", out_last_o on '8'.

Source files
------------

// File: rtl/num_formatter.sv
// Streams a BCD significand and binary exponent as an ASCII scientific-notation string,
// one character per ready/valid beat, after a bit-serial double-dabble exponent conversion.
module num_formatter #(
   parameter int unsigned NumDigits     = 8,
   parameter int unsigned ExpWidth      = 8,
   parameter bit          AppendNewline = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   error_i,
   input  logic                   sign_i,
   input  logic [4*NumDigits-1:0] significand_i,
   input  logic [ExpWidth-1:0]    exponent_i,
   input  logic                   compact_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [7:0]             out_char_o,
   output logic                   out_last_o,
   output logic                   busy_o
);

   // Enough decimal digits to hold 2^(ExpWidth-1), the largest magnitude.
   localparam int unsigned ExpDigits = ((ExpWidth - 1) * 3) / 10 + 1;
   localparam int unsigned BcdWidth  = 4 * ExpDigits;
   localparam int unsigned PosWidth  = $clog2(NumDigits + 20);
   localparam int unsigned CntWidth  = $clog2(ExpWidth + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

   state_t                 state;
   logic                   err;
   logic                   neg;
   logic                   exp_neg;
   logic                   compact;
   logic [4*NumDigits-1:0] sig;
   logic [ExpWidth-1:0]    mag;
   logic [BcdWidth-1:0]    bcd;
   logic [BcdWidth-1:0]    bcd_adj;
   logic [CntWidth-1:0]    cnt;
   logic [PosWidth-1:0]    pos;
   logic [7:0]             next_char;
   logic                   next_last;

   assign in_ready_o = (state == IDLE);
   assign busy_o     = (state != IDLE);

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
   endfunction

   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < ExpDigits; i++) begin
         if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Character at index pos+1, derived from the string layout rather than a sub-state.
   always_comb begin
      int unsigned k;
      int unsigned base;
      int unsigned sfx_len;
      int unsigned exp_start;
      int unsigned nd;
      int unsigned total;
      logic [47:0] sfx;
      next_char = '0;
      next_last = 1'b0;
      sfx       = " x 10^";
      nd        = 1;
      for (int unsigned i = 1; i < ExpDigits; i++) begin
         if (bcd[4*i +: 4] != 4'd0) nd = i + 1;
      end
      k         = 32'(pos) + 1;
      base      = NumDigits + 3;
      sfx_len   = compact ? 1 : 6;
      exp_start = base + sfx_len + (exp_neg ? 1 : 0);
      total     = exp_start + nd + (AppendNewline ? 1 : 0);
      if (k == 1) begin
         next_char = neg ? 8'h2D : 8'h20;
      end else if (k == 2) begin
         next_char = digit_char(sig[4*(NumDigits-1) +: 4]);
      end else if (k == 3) begin
         next_char = 8'h2E;
      end else if (k < base) begin
         next_char = digit_char(sig[4*(base-1-k) +: 4]);
      end else if (k < base + sfx_len) begin
         next_char = compact ? 8'h65 : sfx[8*(5-(k-base)) +: 8];
      end else if (k < exp_start) begin
         next_char = 8'h2D;
      end else if (k < exp_start + nd) begin
         next_char = 8'h30 + {4'h0, bcd[4*(exp_start+nd-1-k) +: 4]};
      end else begin
         next_char = 8'h0A;
      end
      next_last = (k == total - 1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= IDLE;
         err         <= 1'b0;
         neg         <= 1'b0;
         exp_neg     <= 1'b0;
         compact     <= 1'b0;
         sig         <= '0;
         mag         <= '0;
         bcd         <= '0;
         cnt         <= '0;
         pos         <= '0;
         out_valid_o <= 1'b0;
         out_last_o  <= 1'b0;
         out_char_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid_i) begin
                  err     <= error_i;
                  neg     <= sign_i;
                  sig     <= significand_i;
                  compact <= compact_i;
                  exp_neg <= exponent_i[ExpWidth-1];
                  // Unsigned negate: the most negative value maps to 2^(ExpWidth-1).
                  mag     <= exponent_i[ExpWidth-1] ? (~exponent_i + 1'b1) : exponent_i;
                  bcd     <= '0;
                  cnt     <= '0;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               {bcd, mag} <= {bcd_adj[BcdWidth-2:0], mag, 1'b0};
               cnt        <= cnt + 1'b1;
               if (cnt == CntWidth'(ExpWidth - 1)) begin
                  state       <= EMIT;
                  out_valid_o <= 1'b1;
                  out_char_o  <= err ? 8'h45 : 8'h20;
                  out_last_o  <= 1'b0;
                  pos         <= '0;
               end
            end
            EMIT: begin
               if (out_ready_i) begin
                  if (out_last_o) begin
                     state       <= IDLE;
                     out_valid_o <= 1'b0;
                     out_last_o  <= 1'b0;
                     out_char_o  <= '0;
                  end else begin
                     pos        <= pos + 1'b1;
                     out_char_o <= next_char;
                     out_last_o <= next_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_num_formatter.sv
// Randomized and directed checks of num_formatter against a string-building reference model.
module tb_num_formatter;

   localparam int EW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, err_in, sign_in, compact_in;
   logic [31:0] sig_in;
   logic [7:0]  exp_in;
   logic        out_valid, out_ready, out_last, busy;
   logic [7:0]  out_char;

   logic        s_in_valid, s_in_ready, s_compact;
   logic [15:0] s_sig;
   logic [3:0]  s_exp;
   logic        s_out_valid, s_out_last, s_busy;
   logic [7:0]  s_out_char;

   num_formatter #(.NumDigits(8), .ExpWidth(EW), .AppendNewline(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .error_i(err_in), .sign_i(sign_in), .significand_i(sig_in), .exponent_i(exp_in),
      .compact_i(compact_in), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_char_o(out_char), .out_last_o(out_last), .busy_o(busy)
   );

   num_formatter #(.NumDigits(4), .ExpWidth(4), .AppendNewline(1'b0)) dut_small (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
      .error_i(1'b0), .sign_i(1'b0), .significand_i(s_sig), .exponent_i(s_exp),
      .compact_i(s_compact), .out_valid_o(s_out_valid), .out_ready_i(1'b1),
      .out_char_o(s_out_char), .out_last_o(s_out_last), .busy_o(s_busy)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   byte unsigned exp_q[$];
   byte unsigned got_q[$];
   bit           last_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Reference: the string assembled with plain text formatting.
   function automatic void build_expected(input bit e, input bit s, input logic [31:0] sig,
                                          input int nd, input int ex, input bit cmp, input bit nl);
      string es;
      string sfx;
      int    d;
      exp_q.delete();
      exp_q.push_back(e ? 8'h45 : 8'h20);
      exp_q.push_back(s ? 8'h2D : 8'h20);
      for (int i = nd - 1; i >= 0; i--) begin
         d = int'((sig >> (4 * i)) & 32'hF);
         exp_q.push_back(d > 9 ? 8'h3F : 8'(48 + d));
         if (i == nd - 1) exp_q.push_back(8'h2E);
      end
      sfx = cmp ? "e" : " x 10^";
      for (int i = 0; i < sfx.len(); i++) exp_q.push_back(sfx[i]);
      if (ex < 0) exp_q.push_back(8'h2D);
      es = $sformatf("%0d", (ex < 0) ? -ex : ex);
      for (int i = 0; i < es.len(); i++) exp_q.push_back(es[i]);
      if (nl) exp_q.push_back(8'h0A);
   endfunction

   task automatic compare_string(input string pfx);
      check_eq({pfx, "_length"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check_eq($sformatf("%s_char%0d", pfx, i), 32'(got_q[i]), 32'(exp_q[i]));
         check_eq($sformatf("%s_last%0d", pfx, i), 32'(last_q[i]), 32'(i == exp_q.size() - 1));
      end
   endtask

   // Called at posedge+1 with the main DUT idle; returns at posedge+1 once out_valid is up.
   task automatic send(input bit e, input bit s, input logic [31:0] sig, input int ex, input bit cmp);
      int cyc;
      err_in = e; sign_in = s; sig_in = sig; exp_in = 8'(ex); compact_in = cmp; in_valid = 1'b1;
      check_eq("in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      cyc = 1;
      check_eq("busy_convert", 32'(busy), 32'd1);
      while (!out_valid && cyc < 50) begin
         in_valid = 1'($urandom); err_in = 1'($urandom); sign_in = 1'($urandom);
         sig_in = $urandom; exp_in = 8'($urandom); compact_in = 1'($urandom);
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check_eq("latency", 32'(cyc), 32'(EW + 1));
   endtask

   task automatic collect(input bit stall, input int abort_at);
      int          cyc;
      bit          done;
      bit          held_v;
      logic [7:0]  held_c;
      logic        held_l;
      cyc = 0; done = 1'b0; held_v = 1'b0; held_c = '0; held_l = 1'b0;
      got_q.delete(); last_q.delete();
      while (!done && cyc < 2000) begin
         if (held_v) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_char", 32'(out_char), 32'(held_c));
            check_eq("stall_last", 32'(out_last), 32'(held_l));
         end
         if (abort_at >= 0 && got_q.size() == abort_at && out_valid) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         out_ready = stall ? 1'($urandom) : 1'b1;
         held_v = 1'b0;
         if (out_valid && out_ready) begin
            got_q.push_back(out_char);
            last_q.push_back(out_last);
            if (out_last) done = 1'b1;
         end else if (out_valid) begin
            held_v = 1'b1; held_c = out_char; held_l = out_last;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("string_done", 32'(done), 32'd1);
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("ready_after", 32'(in_ready), 32'd1);
      check_eq("valid_after", 32'(out_valid), 32'd0);
   endtask

   task automatic run(input string tag, input bit e, input bit s, input logic [31:0] sig,
                      input int ex, input bit cmp, input bit stall);
      build_expected(e, s, sig, 8, ex, cmp, 1'b1);
      send(e, s, sig, ex, cmp);
      collect(stall, -1);
      compare_string(tag);
   endtask

   task automatic small_run(input logic [15:0] sig, input int ex, input bit cmp);
      int cyc;
      bit done;
      s_sig = sig; s_exp = 4'(ex); s_compact = cmp; s_in_valid = 1'b1;
      check_eq("s_in_ready", 32'(s_in_ready), 32'd1);
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      cyc = 1;
      while (!s_out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("s_latency", 32'(cyc), 32'd5);
      got_q.delete(); last_q.delete();
      done = 1'b0;
      while (!done && cyc < 200) begin
         if (s_out_valid) begin
            got_q.push_back(s_out_char);
            last_q.push_back(s_out_last);
            if (s_out_last) done = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("s_busy_after", 32'(s_busy), 32'd0);
      build_expected(1'b0, 1'b0, {16'h0, sig}, 4, ex, cmp, 1'b0);
      compare_string("small");
   endtask

   initial begin
      logic [15:0] ssig;
      int          seen;
      rst_n = 1'b0; in_valid = 1'b0; err_in = 1'b0; sign_in = 1'b0; sig_in = '0;
      exp_in = '0; compact_in = 1'b0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_sig = '0; s_exp = '0; s_compact = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_last", 32'(out_last), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_out_char", 32'(out_char), 32'd0);

      run("full_neg", 1'b0, 1'b1, 32'h1234_5678, -12, 1'b0, 1'b0);
      check_eq("full_neg_beats", 32'(got_q.size()), 32'd21);

      run("compact_zero", 1'b1, 1'b0, 32'h0, 0, 1'b1, 1'b0);
      run("min_exp", 1'b0, 1'b0, 32'h1234_567A, -128, 1'b0, 1'b0);
      run("max_exp", 1'b1, 1'b1, 32'h9876_5432, 127, 1'b1, 1'b1);
      run("stall", 1'b0, 1'b1, 32'h1234_5678, -12, 1'b0, 1'b1);

      // Reset in the middle of a string, then a fresh number.
      build_expected(1'b0, 1'b0, 32'h5555_5555, 8, 33, 1'b0, 1'b1);
      send(1'b0, 1'b0, 32'h5555_5555, 33, 1'b0);
      collect(1'b0, 4);
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_char", 32'(out_char), 32'd0);
      check_eq("mid_rst_last", 32'(out_last), 32'd0);
      out_ready = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check_eq("mid_rst_stray", 32'(seen), 32'd0);
      run("after_rst", 1'b0, 1'b0, 32'h2718_2818, 7, 1'b1, 1'b0);

      for (int t = 0; t < 12; t++) begin
         run($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), $urandom,
             int'($urandom_range(0, 255)) - 128, 1'($urandom), 1'($urandom));
      end

      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 4; i++) ssig[4*i +: 4] = 4'($urandom_range(0, 9));
         if (t == 0) small_run(ssig, -8, 1'b0);
         else small_run(ssig, int'($urandom_range(0, 15)) - 8, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
